// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: opcode constants, immediate format codes and
// the occupancy states of the decode-stage skid buffer.
package cpu_types_pkg;

  localparam logic [6:0] OPC_RTYPE    = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE    = 7'b0010011;
  localparam logic [6:0] OPC_ITYPE_LW = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_STYPE    = 7'b0100011;
  localparam logic [6:0] OPC_BTYPE    = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_HALT     = 7'b1111111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_J    = 3'd4,
    FMT_U    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational immediate decoder: format, sign-extended immediate, illegal flag
// and PC-relative target enable. SYSTEM/CSR immediates need IMM_GEN_ZICSR_EN.
module imm_decode_comb
  import cpu_types_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output fmt_t            fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal,
  output logic            tgt_en
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    fmt     = FMT_NONE;
    imm     = '0;
    illegal = 1'b0;
    tgt_en  = 1'b0;

    case (instr[6:0])
      OPC_ITYPE, OPC_ITYPE_LW, OPC_JALR: begin
        // JALR targets depend on rs1, so no target is precomputed for it.
        fmt = FMT_I;
        imm = XLEN'($signed(instr[31:20]));
      end
      OPC_STYPE: begin
        fmt = FMT_S;
        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OPC_BTYPE: begin
        fmt    = FMT_B;
        imm    = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        tgt_en = 1'b1;
      end
      OPC_JAL: begin
        fmt    = FMT_J;
        imm    = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
        tgt_en = 1'b1;
      end
      OPC_LUI: begin
        fmt = FMT_U;
        imm = XLEN'($signed({instr[31:12], 12'b0}));
      end
      OPC_AUIPC: begin
        fmt    = FMT_U;
        imm    = XLEN'($signed({instr[31:12], 12'b0}));
        tgt_en = 1'b1;
      end
      OPC_RTYPE, OPC_HALT: begin
        // Legal but carry no immediate.
        fmt = FMT_NONE;
      end
`ifdef IMM_GEN_ZICSR_EN
      OPC_SYSTEM: begin
        if (instr[14]) begin
          fmt = FMT_Z;
          imm = XLEN'(instr[19:15]);
        end
      end
`endif
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-generation decode stage with a 2-entry skid buffer so
// in_ready is a flop. Optional CSR immediates are enabled by IMM_GEN_ZICSR_EN.
module imm_decode_stage
  import cpu_types_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output fmt_t            out_fmt,
  output logic [PC_W-1:0] out_target,
  output logic            out_illegal
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] imm;
    fmt_t            fmt;
    logic [PC_W-1:0] target;
    logic            illegal;
  } entry_t;

  fmt_t            dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            dec_tgt_en;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr   (in_instr),
    .fmt     (dec_fmt),
    .imm     (dec_imm),
    .illegal (dec_illegal),
    .tgt_en  (dec_tgt_en)
  );

  entry_t      in_entry;
  entry_t      head_d, head_q;
  entry_t      skid_d, skid_q;
  skid_state_t state_d, state_q;
  logic        out_valid_d, out_valid_q;
  logic        in_ready_d, in_ready_q;
  logic        accept;
  logic        pop;

  always_comb begin
    in_entry.instr   = in_instr;
    in_entry.pc      = in_pc;
    in_entry.imm     = dec_imm;
    in_entry.fmt     = dec_fmt;
    in_entry.target  = dec_tgt_en ? (in_pc + dec_imm[PC_W-1:0]) : '0;
    in_entry.illegal = dec_illegal;
  end

  assign accept = in_valid && in_ready_q && !flush;
  assign pop    = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_d  = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          case ({accept, pop})
            2'b10: begin
              skid_d  = in_entry;
              state_d = ST_FULL;
            end
            2'b11: head_d  = in_entry;
            2'b01: state_d = ST_EMPTY;
            default: state_d = ST_ONE;
          endcase
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can move the buffer.
          if (pop) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      // NOTE: the two entry registers are reset too, so every output reads 0 out of reset.
      head_q      <= '0;
      skid_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = head_q.instr;
  assign out_pc      = head_q.pc;
  assign out_imm     = head_q.imm;
  assign out_fmt     = head_q.fmt;
  assign out_target  = head_q.target;
  assign out_illegal = head_q.illegal;

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered immediate-generation pipeline stage for the decode path. It accepts one fetched instruction and PC per handshake and classifies the instruction format. It emits the XLEN-wide sign-extended immediate and, for PC-relative formats, the precomputed target PC one cycle later. A 2-entry skid buffer keeps `in_ready` registered, so fetch→decode backpressure never forms a combinational loop; `flush` drops all in-flight entries on a redirect.

## Interface
- `XLEN`, default 32: immediate and datapath width; legal values are 32 and 64.
- `PC_W`, default 32: PC width; must satisfy PC_W ≤ XLEN.
- `CLK` input 1: clock; all state updates on the rising edge.
- `nRST` input 1: reset; asynchronous, active-low.
- `flush` input 1: synchronous drop of all buffered entries.
- `in_valid` input 1: upstream holds a valid instruction.
- `in_ready` output 1: stage can accept; registered.
- `in_instr` input 32: instruction word.
- `in_pc` input PC_W: PC of `in_instr`.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: downstream accepts the head entry.
- `out_instr` output 32: instruction passthrough.
- `out_pc` output PC_W: PC passthrough.
- `out_imm` output XLEN: decoded immediate.
- `out_fmt` output 3: `fmt_t` format code.
- `out_target` output PC_W: `pc + imm` for B, J and AUIPC formats; 0 otherwise.
- `out_illegal` output 1: opcode is not recognised.

## Operation
- Decode is combinational on `in_instr[6:0]`; its result is written into storage on accept.
  - ITYPE, ITYPE_LW, JALR → FMT_I, imm = sext(instr[31:20]).
  - STYPE → FMT_S, imm = sext({[31:25],[11:7]}).
  - BTYPE → FMT_B, imm = sext({[31],[7],[30:25],[11:8],0}).
  - JAL → FMT_J, imm = sext({[31],[19:12],[20],[30:21],0}).
  - LUI, AUIPC → FMT_U, imm = sext({[31:12],12'b0}); bit 31 extends for XLEN=64.
  - RTYPE, HALT → FMT_NONE, imm = 0.
  - Any other opcode → FMT_NONE, imm = 0, `out_illegal` = 1. Illegal entries still flow through the stage in order; they are never dropped.
- Target: `out_target = (in_pc + imm[PC_W-1:0])` mod 2^PC_W, computed before storage, for FMT_B, FMT_J and AUIPC only. JALR target = 0, because it depends on rs1.
- Accept condition: `in_valid && in_ready && !flush`. Pop condition: `out_valid && out_ready`.
- State machine:
  - EMPTY: no entries.
  - ONE: head register only.
  - FULL: head plus skid.
- Transitions:
  - EMPTY→ONE on accept.
  - ONE→EMPTY on pop without accept.
  - ONE stays ONE on pop with simultaneous accept (the new entry goes to head).
  - ONE→FULL on accept without pop (the new entry goes to skid).
  - FULL→ONE on pop (skid moves to head). There is no accept in FULL.
- `in_ready` = (next state ≠ FULL), registered.
- `flush` → next state EMPTY. Flush wins over a simultaneous accept or pop; the input in that cycle is discarded.

## Timing
- Latency: accept at edge N → `out_valid` high after edge N; the entry is visible in cycle N+1.
- With `out_ready` held high, throughput is 1 instruction/cycle.
- All outputs come directly from registers.
- Output fields are stable while `out_valid && !out_ready`.
- Reset value of every output is 0, except `in_ready` = 1. State resets to EMPTY.
- If `nRST` is asserted mid-transfer, all entries are lost with no partial output.
- After release, the first accept is possible on the first edge.

## Configuration
- `IMM_GEN_ZICSR_EN` defined: SYSTEM opcode (1110011) is legal.
  - funct3[2] = 1 → FMT_Z, imm = zext(instr[19:15]).
  - Any other funct3 → FMT_NONE, imm = 0.
- `IMM_GEN_ZICSR_EN` undefined: SYSTEM is illegal, and FMT_Z is never produced.

## Structure
- `cpu_types_pkg` gains `fmt_t` (FMT_NONE=0, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_Z) and the SYSTEM opcode constant.
- Opcode constants are reused from the same package.
- One sub-module, `imm_decode_comb`: the combinational decoder, producing fmt, imm, illegal and target-enable from an instruction, parametrised by XLEN.
- The stage instantiates `imm_decode_comb` once on the input side and adds the skid and FSM logic.

## Test plan
- Test 1: `0xFFF00093` (addi x1,x0,-1) at pc 0x0.
  - Expect `out_imm` = 0xFFFFFFFF, FMT_I, `out_illegal` = 0, `out_target` = 0, one cycle later.
- Test 2: `0xFE000EE3` (beq -4) at pc 0x100.
  - Expect `out_imm` = 0xFFFFFFFC, FMT_B, `out_target` = 0x0FC.
- Test 3: XLEN=64, `0x80000037` (lui).
  - Expect `out_imm` = 0xFFFFFFFF80000000, FMT_U.
- Test 4: stream 4 instructions with `out_ready` = 0 for 3 cycles.
  - Expect `in_ready` to fall after 2 accepts and no loss.
  - After release, expect outputs in order at 1 per cycle, with fields stable while stalled.
- Test 5: FULL state with `flush` and `in_valid` asserted together.
  - Expect next cycle `out_valid` = 0, `in_ready` = 1, and the flushed input absent from the output.
- Test 6: `0x3002D073` (csrrwi).
  - With `IMM_GEN_ZICSR_EN`: imm = 5, FMT_Z.
  - Without it: `out_illegal` = 1, imm = 0.
  - Opcode `0x0000000B`: expect `out_illegal` = 1 in both builds.
